// File: rtl/axil_regbank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank: response codes,
// write/read channel state encodings and index-width helpers.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int byte_shift(input int strb_w);
    return (strb_w > 1) ? $clog2(strb_w) : 0;
  endfunction

endpackage

// File: rtl/axil_regbank_decode.sv
// Combinational address decode: byte address -> register index, hit and error.
// AXIL_REGBANK_PROT_CHECK_EN: unprivileged accesses (prot[0] = 0) are errors.
module axil_regbank_decode
  import axil_regbank_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    IDX_W      = idx_width(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            prot,
  output logic [IDX_W-1:0]      idx,
  output logic                  hit,
  output logic                  err
);

  localparam int SHIFT = byte_shift(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word;

  assign off  = addr - BASE_ADDR;
  // Full-width word offset is compared so large offsets cannot alias into range.
  assign word = off >> SHIFT;
  assign hit  = (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS));
  assign idx  = word[IDX_W-1:0];

`ifdef AXIL_REGBANK_PROT_CHECK_EN
  logic unused_prot;
  assign unused_prot = ^prot[2:1];
  assign err = !hit || !prot[0];
`else
  logic unused_prot;
  assign unused_prot = ^prot;
  assign err = !hit;
`endif

endmodule

// File: rtl/axi4_lite_regbank.sv
// Parametrised AXI4-Lite register bank with RW / RO / W1C registers.
// AXIL_REGBANK_PROT_CHECK_EN: reject unprivileged accesses with SLVERR.
module axi4_lite_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                             ADDR_WIDTH = 32,
  parameter int                             DATA_WIDTH = 32,
  parameter int                             NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR  = '0,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]            W1C_MASK   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0,
  localparam int                            STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IDX_W = idx_width(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] q_arr, hw_arr;
  assign hw_arr = hw_in;
  assign reg_q  = q_arr;

  // ---------------- write channel ----------------
  wstate_e                 w_state, w_next;
  logic                    aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_eff;
  logic [2:0]              aw_prot_q, aw_prot_eff;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_eff, w_bmask;
  logic [STRB_WIDTH-1:0]   w_strb_q, w_strb_eff;
  logic [IDX_W-1:0]        aw_idx;
  logic                    aw_hit, aw_err;
  logic [NUM_REGS-1:0]     we;

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    commit  = 1'b0;
    unique case (w_state)
      W_IDLE:    begin awready = 1'b1; wready = 1'b1; end
      W_HAVE_AW: wready  = 1'b1;
      W_HAVE_W:  awready = 1'b1;
      default:   ;
    endcase
    awready = awready & aresetn;
    wready  = wready & aresetn;
    aw_hs   = awvalid & awready;
    w_hs    = wvalid & wready;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin w_next = W_RESP; commit = 1'b1; end
        else if (aw_hs)         w_next = W_HAVE_AW;
        else if (w_hs)          w_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  begin w_next = W_RESP; commit = 1'b1; end
      W_HAVE_W:  if (aw_hs) begin w_next = W_RESP; commit = 1'b1; end
      W_RESP:    if (bready) w_next = W_IDLE;
      default:   w_next = W_IDLE;
    endcase
  end

  // On the completing edge, the half that arrives now comes straight off the bus.
  assign aw_addr_eff = (w_state == W_HAVE_AW) ? aw_addr_q : awaddr;
  assign aw_prot_eff = (w_state == W_HAVE_AW) ? aw_prot_q : awprot;
  assign w_data_eff  = (w_state == W_HAVE_W)  ? w_data_q  : wdata;
  assign w_strb_eff  = (w_state == W_HAVE_W)  ? w_strb_q  : wstrb;

  for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_bmask
    assign w_bmask[b*8 +: 8] = {8{w_strb_eff[b]}};
  end

  axil_regbank_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS),
    .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_aw_dec (
    .addr(aw_addr_eff), .prot(aw_prot_eff), .idx(aw_idx), .hit(aw_hit), .err(aw_err)
  );

  always_comb begin
    we = '0;
    if (commit && !aw_err) we[aw_idx] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      w_state  <= w_next;
      wr_pulse <= we;
      if (aw_hs) begin
        aw_addr_q <= awaddr;
        aw_prot_q <= awprot;
      end
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) bresp <= aw_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign bvalid = (w_state == W_RESP);

  // ---------------- register storage ----------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign q_arr[i] = hw_arr[i];
    end else if (W1C_MASK[i]) begin : g_w1c
      logic [DATA_WIDTH-1:0] q, clr;
      assign clr = we[i] ? (w_data_eff & w_bmask) : '0;
      // Hardware set is OR'd last so it wins over a same-cycle clear.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) q <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
        else          q <= (q & ~clr) | hw_arr[i];
      end
      assign q_arr[i] = q;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)   q <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
        else if (we[i]) q <= (q & ~w_bmask) | (w_data_eff & w_bmask);
      end
      assign q_arr[i] = q;
    end
  end

  // ---------------- read channel ----------------
  rstate_e          r_state, r_next;
  logic             ar_hs;
  logic [IDX_W-1:0] ar_idx;
  logic             ar_hit, ar_err;

  axil_regbank_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS),
    .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_ar_dec (
    .addr(araddr), .prot(arprot), .idx(ar_idx), .hit(ar_hit), .err(ar_err)
  );

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    unique case (r_state)
      R_IDLE:  arready = aresetn;
      R_DATA:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
    ar_hs = arvalid & arready;
    if (ar_hs) r_next = R_DATA;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rresp <= ar_err ? RESP_SLVERR : RESP_OKAY;
        rdata <= ar_err ? '0 : q_arr[ar_idx];
      end
    end
  end

  assign rvalid = (r_state == R_DATA);

  logic unused_ok;
  assign unused_ok = ^{hw_in, aw_hit, ar_hit};

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Self-checking bench for axi4_lite_regbank: directed steps plus a randomized
// phase checked against a word/byte-level register model.
module tb_axi4_lite_regbank;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [NR*DW-1:0] RV      = (NR*DW)'(32'hA5A5_0000) << (2*DW);
  localparam logic [NR-1:0]    RO_M    = 16'h0080;
  localparam logic [NR-1:0]    W1C_M   = 16'h0020;
  localparam logic [1:0]       OKAY    = 2'b00;
  localparam logic [1:0]       SLVERR  = 2'b10;

  logic           aclk, aresetn;
  logic [AW-1:0]  awaddr, araddr;
  logic [2:0]     awprot, arprot;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rvalid, rready;
  logic [DW-1:0]  wdata, rdata;
  logic [3:0]     wstrb;
  logic [1:0]     bresp, rresp;
  logic [NR*DW-1:0] reg_q, hw_in;
  logic [NR-1:0]  wr_pulse;

  logic [31:0] hw5, hw7;
  assign hw_in = ((NR*DW)'(hw7) << (7*DW)) | ((NR*DW)'(hw5) << (5*DW));

  axi4_lite_regbank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR('0),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RESET_VAL(RV)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q), .hw_in(hw_in), .wr_pulse(wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: register index from the byte address, byte-wise update.
  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int idx;
    if (addr >= NR*4) return;
    idx = int'(addr >> 2);
    if (idx == 7) return;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        if (idx == 5) model[idx][b*8 +: 8] = model[idx][b*8 +: 8] & ~data[b*8 +: 8];
        else          model[idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end
    if (idx == 5) model[5] = model[5] | hw5;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (addr >= NR*4) return 32'h0;
    if ((addr >> 2) == 7) return hw7;
    return model[addr >> 2];
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly);
    int cyc;
    bit aw_done, w_done, aw_now, w_now;
    logic [NR-1:0] exp_pulse;
    logic [1:0] exp_resp;
    awaddr = addr; awprot = 3'b001; wdata = data; wstrb = strb;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 30) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_now  = awvalid && awready;
      w_now   = wvalid && wready;
      @(posedge aclk); #1;
      aw_done |= aw_now;
      w_done  |= w_now;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake", {aw_done, w_done}, 2'b11);
    exp_resp  = (addr < NR*4) ? OKAY : SLVERR;
    exp_pulse = (addr < NR*4) ? (NR'(1) << (addr >> 2)) : '0;
    model_write(addr, data, strb);
    chk("bvalid_latency", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp);
    chk("wr_pulse", wr_pulse, exp_pulse);
    if (addr < NR*4) chk("reg_q_after_wr", reg_q[(addr >> 2)*DW +: DW], model_read(addr));
    bready = 1;
    @(posedge aclk); #1;
    bready = 0;
    chk("bvalid_drop", bvalid, 1'b0);
    chk("wr_pulse_once", wr_pulse, '0);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
    int cyc;
    bit done, now;
    araddr = addr; arprot = 3'b001;
    cyc = 0; done = 0;
    while (!done && cyc < 30) begin
      arvalid = 1;
      now = arvalid && arready;
      @(posedge aclk); #1;
      done = now;
      cyc++;
    end
    arvalid = 0;
    chk("rd_handshake", done, 1'b1);
    chk("rvalid_latency", rvalid, 1'b1);
    chk("rresp", rresp, (addr < NR*4) ? OKAY : SLVERR);
    chk("rdata_model", rdata, model_read(addr));
    data = rdata;
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;
    chk("rvalid_drop", rvalid, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR*DW-1:0] rv_v;
    logic [31:0] rd, held;
    rv_v = RV;
    for (int i = 0; i < NR; i++) model[i] = rv_v[i*DW +: DW];
    hw5 = 0; hw7 = 32'hCAFE_F00D;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    aresetn = 0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resp_data", {bresp, rresp, rdata}, '0);
    chk("rst_wr_pulse", wr_pulse, '0);
    chk("rst_reg2", reg_q[2*DW +: DW], 32'hA5A5_0000);
    aresetn = 1;
    #1;
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);
    @(posedge aclk); #1;

    do_read(32'h08, rd);
    chk("reset_val_reg2", rd, 32'hA5A5_0000);

    // Ordering: W leads AW by two cycles, then AW leads W
    do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 2, 0);
    do_read(32'h04, rd);
    chk("w_first_readback", rd, 32'hDEAD_BEEF);
    do_write(32'h0C, 32'hDEAD_BEEF, 4'hF, 0, 2);
    do_read(32'h0C, rd);
    chk("aw_first_readback", rd, 32'hDEAD_BEEF);

    // Partial strobes
    do_write(32'h0C, 32'h1122_3344, 4'hF, 0, 0);
    do_write(32'h0C, 32'hFFFF_FFFF, 4'h5, 0, 0);
    do_read(32'h0C, rd);
    chk("strobe_merge", rd, 32'h11FF_33FF);

    // W1C: hardware sets bits, software clears
    hw5 = 32'h3;
    @(posedge aclk); #1;
    hw5 = 0;
    model[5] = model[5] | 32'h3;
    chk("w1c_set", reg_q[5*DW +: DW], 32'h3);
    do_write(32'h14, 32'h1, 4'hF, 0, 0);
    do_read(32'h14, rd);
    chk("w1c_clear", rd, 32'h2);
    hw5 = 32'h1;
    model[5] = model[5] | 32'h1;
    do_write(32'h14, 32'h1, 4'hF, 0, 0);
    hw5 = 0;
    do_read(32'h14, rd);
    chk("w1c_set_wins", rd, 32'h3);

    // Out of range and read-only
    do_write(32'h40, 32'h1234_5678, 4'hF, 0, 0);
    do_read(32'h40, rd);
    chk("miss_rdata", rd, 32'h0);
    do_write(32'h1C, 32'h5555_5555, 4'hF, 1, 0);
    do_read(32'h1C, rd);
    chk("ro_unchanged", rd, 32'hCAFE_F00D);
    do_read(32'h07, rd);
    chk("low_bits_ignored", rd, 32'hDEAD_BEEF);

    // Back-pressure with concurrent read and write to the same register
    awaddr = 32'h04; awprot = 3'b001; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    araddr = 32'h04; arprot = 3'b001;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge aclk); #1;
    held = model_read(32'h04);
    model_write(32'h04, 32'h0BAD_F00D, 4'hF);
    chk("bp_rdata_old", rdata, held);
    chk("bp_pulse", wr_pulse, NR'(1) << 1);
    awaddr = 32'h08; wdata = 32'h7777_7777; araddr = 32'h08;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valids", {bvalid, rvalid}, 2'b11);
      chk("bp_no_accept", {awready, wready, arready}, 3'b000);
      chk("bp_stable", {bresp, rresp, rdata}, {OKAY, OKAY, held});
      if (c > 0) chk("bp_pulse_gone", wr_pulse, '0);
      @(posedge aclk); #1;
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 1; rready = 1;
    @(posedge aclk); #1;
    bready = 0; rready = 0;
    chk("bp_release", {bvalid, rvalid}, 2'b00);
    do_read(32'h04, rd);
    chk("bp_new_value", rd, 32'h0BAD_F00D);
    do_read(32'h08, rd);
    chk("bp_second_dropped", rd, 32'hA5A5_0000);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 17) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) hw7 = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      else
        do_read(a, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_lite_regbank.md
# axi4_lite_regbank

Parametrised AXI4-Lite register-bank slave: successor to the fixed 8-register slave. Register count, data width, base address, per-register access type (RW / RO / W1C) and reset values are set by parameters. It sits behind the AXI4-Lite interconnect. It presents the register contents and write-strobe pulses to the peripheral core, and takes status values from it.

## Interface
Parameters:
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: data width; only 32 or 64 are legal. STRB_WIDTH = DATA_WIDTH/8.
- NUM_REGS, 16: number of registers, 2..256.
- BASE_ADDR, 0: byte address of register 0; must be aligned to NUM_REGS*STRB_WIDTH.
- RO_MASK, '0: NUM_REGS bits. A set bit makes that register read-only; its value comes from hw_in.
- W1C_MASK, '0: NUM_REGS bits. A set bit makes that register write-1-to-clear, set by hw_in. RO takes precedence over W1C.
- RESET_VAL, '0: NUM_REGS*DATA_WIDTH bits; reset value of each RW and W1C register.

Ports:
- aclk, in, 1: clock.
- aresetn, in, 1: reset. Asynchronous assert, active-low.
- awaddr, awprot, awvalid, awready: AW channel (ADDR_WIDTH, 3, 1, 1).
- wdata, wstrb, wvalid, wready: W channel (DATA_WIDTH, STRB_WIDTH, 1, 1).
- bresp, bvalid, bready: B channel (2, 1, 1).
- araddr, arprot, arvalid, arready: AR channel (ADDR_WIDTH, 3, 1, 1).
- rdata, rresp, rvalid, rready: R channel (DATA_WIDTH, 2, 1, 1).
- reg_q, out, NUM_REGS*DATA_WIDTH: current value of every register. Register i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- hw_in, in, NUM_REGS*DATA_WIDTH: for RO registers, the read value. For W1C registers, bits to set. Ignored for RW registers.
- wr_pulse, out, NUM_REGS: one-cycle pulse on the commit of an accepted write to register i, including writes to RO registers.

## Operation
- Address decode: off = addr - BASE_ADDR, idx = off >> log2(STRB_WIDTH). Low log2(STRB_WIDTH) bits are ignored. Hit when addr >= BASE_ADDR and idx < NUM_REGS.
- Write FSM states:
  - W_IDLE: awready = wready = 1.
  - W_HAVE_AW: AW latched; wready = 1, awready = 0.
  - W_HAVE_W: W latched; awready = 1, wready = 0.
  - W_RESP: bvalid = 1, both readies 0.
- Write FSM transitions:
  - From IDLE: AW+W together go to RESP; AW alone goes to HAVE_AW; W alone goes to HAVE_W.
  - HAVE_AW or HAVE_W goes to RESP when the missing half handshakes.
  - RESP goes to IDLE on bready.
- Write commit happens on the edge entering W_RESP:
  - RW register: bytes with wstrb[b] = 1 take wdata; other bytes hold.
  - W1C register: bits set in wdata, within strobed bytes, clear.
  - RO register: no change, bresp OKAY.
  - Miss: no change, bresp SLVERR (2'b10), no wr_pulse.
- W1C register update every cycle: q <= (q & ~clear) | hw_in. Set wins over a simultaneous clear.
- Read FSM states:
  - R_IDLE: arready = 1.
  - R_DATA: rvalid = 1, arready = 0; returns to R_IDLE on rready.
- Read data and response: on the AR handshake edge, rdata and rresp are registered.
  - RO register: hw_in slice as sampled at that edge.
  - Hit: reg_q value (old value if a write commits on the same edge), rresp OKAY.
  - Miss: rdata 0, rresp SLVERR.
- Read and write channels are fully independent and may run concurrently.

## Timing
- Reset (aresetn low): all FSMs go to IDLE.
  - bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, wr_pulse = 0.
  - Registers take RESET_VAL.
  - awready, wready and arready are forced 0 while aresetn is low, and are 1 from the first cycle after release.
- Write latency: bvalid rises 1 cycle after the completing handshake. wr_pulse and the reg_q update are visible in that same cycle.
- Read latency: rvalid rises 1 cycle after the AR handshake.
- Peak throughput is one transaction per 2 cycles per channel when bready/rready are held high.
- bvalid/bresp and rvalid/rdata/rresp stay stable until accepted. Stalling bready or rready holds the FSM and back-pressures the channel.
- Reset asserted mid-transaction aborts it with no response. A write already committed is overwritten by RESET_VAL.

## Configuration
- AXIL_REGBANK_PROT_CHECK_EN defined: any access with prot[0] = 0 (unprivileged) gets SLVERR.
  - Writes are dropped and produce no wr_pulse.
  - Reads return rdata 0.
- Not defined: awprot and arprot are ignored.

## Structure
- Package axil_regbank_pkg holds:
  - resp constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - write and read state enums;
  - function clog2-based index-width helpers.
- Sub-module axil_regbank_decode (combinational): inputs addr and prot; outputs idx and hit/err. It is instantiated twice, once for AW and once for AR.

## Test plan
- Reset, 16x32 bank, RESET_VAL reg2 = 0xA5A5_0000: all readies 0 during reset; after release, read 0x08 returns 0xA5A5_0000, OKAY.
- Ordering: W(0xDEAD_BEEF, strb 0xF) then AW 0x04 two cycles later. Separately, AW before W. Both give bresp OKAY, wr_pulse[1], and a readback of 0xDEAD_BEEF.
- Strobe: RW reg holding 0x1122_3344, write 0xFFFF_FFFF with strb 0x5 → readback 0x11FF_33FF.
- W1C: hw_in pulses 0x3 into reg5, then write 0x1 → 0x2. Set and clear of bit0 in the same cycle → bit0 stays 1.
- Out of range: write and read at BASE_ADDR + NUM_REGS*4 → SLVERR, no wr_pulse, rdata 0. Write to an RO reg → OKAY, value unchanged.
- Back-pressure and concurrency: hold bready and rready low for 5 cycles with simultaneous read and write. Responses stay stable, no second AW/AR is accepted, and the read returns the pre-write value.
